// File: rtl/ex_stage.sv
// ex_stage: execute stage that pops decoded packets from a first-word-fall-through FIFO,
// runs ALU / compare / car-command ops in one cycle and unsigned division in 16 more.
// Ports:
//   clk, reset (async active-low)
//   fifo_data/fifo_empty in, fifo_rd_en out  : FIFO head and pop strobe
//   WB_data/WB_reg_addr/WB_reg_write         : registered writeback, one-cycle strobe
//   car_cmd/car_cmd_valid                    : registered car command, one-cycle strobe
//   cmp_eq/cmp_lt                            : flags from the last CMP
//   busy                                     : state is not IDLE
module ex_stage #(
  parameter logic [15:0] OB_THRESHOLD = 16'd100,
  parameter logic [15:0] VEL_LIMIT = 16'd60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [41:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [15:0] WB_data,
  output logic [3:0]  WB_reg_addr,
  output logic        WB_reg_write,
  output logic [1:0]  car_cmd,
  output logic        car_cmd_valid,
  output logic        cmp_eq,
  output logic        cmp_lt,
  output logic        busy
);
  localparam logic [4:0] OP_MOV = 5'd1, OP_ADD = 5'd2, OP_SUB = 5'd3, OP_AND = 5'd4,
                         OP_OR = 5'd5, OP_NOT = 5'd6, OP_MULT = 5'd7, OP_DIV = 5'd8,
                         OP_CMP = 5'd9, OP_OBC = 5'd10, OP_VG = 5'd11, OP_LEFT = 5'd12,
                         OP_RIGHT = 5'd13, OP_STOP = 5'd14, OP_CONT = 5'd15;
  localparam logic [1:0] CMD_STOP = 2'b10, CMD_CONT = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, DIV} state_t;
  state_t state, state_next;
  logic [4:0] op;
  logic [3:0] rd, cnt;
  logic [15:0] a, b, rem, quo, res, rem_next, quo_next;
  logic [16:0] shifted, diff;
  logic [1:0] cmd;
  logic wb_en, cmd_en, obs, ovs, fit, unused_bit;
  assign unused_bit = fifo_data[0];
  assign fifo_rd_en = reset & (state == IDLE) & ~fifo_empty;
  assign busy = state != IDLE;
  assign obs = a < OB_THRESHOLD;
  assign ovs = a > VEL_LIMIT;
  // restoring step: a borrow out of the trial subtraction means the divisor does not fit
  assign shifted = {rem, quo[15]};
  assign diff = shifted - {1'b0, b};
  assign fit = ~diff[16];
  assign rem_next = fit ? diff[15:0] : shifted[15:0];
  assign quo_next = {quo[14:0], fit};
  always_comb begin
    res = 16'h0;
    wb_en = 1'b0;
    cmd = CMD_CONT;
    cmd_en = 1'b0;
    case (op)
      OP_MOV:   begin res = a; wb_en = 1'b1; end
      OP_ADD:   begin res = a + b; wb_en = 1'b1; end
      OP_SUB:   begin res = a - b; wb_en = 1'b1; end
      OP_AND:   begin res = a & b; wb_en = 1'b1; end
      OP_OR:    begin res = a | b; wb_en = 1'b1; end
      OP_NOT:   begin res = ~a; wb_en = 1'b1; end
      OP_MULT:  begin res = a * b; wb_en = 1'b1; end
      OP_DIV:   begin res = 16'hFFFF; wb_en = b == 16'h0; end
      OP_OBC:   begin res = {15'h0, obs}; wb_en = 1'b1; cmd_en = 1'b1; cmd = obs ? CMD_STOP : CMD_CONT; end
      OP_VG:    begin res = {15'h0, ovs}; wb_en = 1'b1; cmd_en = 1'b1; cmd = ovs ? CMD_STOP : CMD_CONT; end
      OP_LEFT:  begin cmd_en = 1'b1; cmd = 2'b00; end
      OP_RIGHT: begin cmd_en = 1'b1; cmd = 2'b01; end
      OP_STOP:  begin cmd_en = 1'b1; cmd = CMD_STOP; end
      OP_CONT:  begin cmd_en = 1'b1; cmd = CMD_CONT; end
      default:  ;
    endcase
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = fifo_rd_en ? EXEC : IDLE;
      EXEC:    state_next = (op == OP_DIV && b != 16'h0) ? DIV : IDLE;
      DIV:     state_next = cnt == 4'd15 ? IDLE : DIV;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      {op, rd, a, b} <= '0;
      {rem, quo, cnt} <= '0;
      WB_data <= 16'h0;
      WB_reg_addr <= 4'h0;
      WB_reg_write <= 1'b0;
      car_cmd <= CMD_STOP;
      car_cmd_valid <= 1'b0;
      cmp_eq <= 1'b0;
      cmp_lt <= 1'b0;
    end else begin
      state <= state_next;
      WB_reg_write <= 1'b0;
      car_cmd_valid <= 1'b0;
      if (fifo_rd_en) {op, rd, a, b} <= fifo_data[41:1];
      if (state == EXEC) begin
        rem <= 16'h0;
        quo <= a;
        cnt <= 4'h0;
        if (wb_en) begin
          WB_data <= res;
          WB_reg_addr <= rd;
          WB_reg_write <= 1'b1;
        end
        if (cmd_en) begin
          car_cmd <= cmd;
          car_cmd_valid <= 1'b1;
        end
        if (op == OP_CMP) begin
          cmp_eq <= a == b;
          cmp_lt <= a < b;
        end
      end
      if (state == DIV) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt + 4'd1;
        if (cnt == 4'd15) begin
          WB_data <= quo_next;
          WB_reg_addr <= rd;
          WB_reg_write <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage with a modelled FWFT FIFO
module tb_ex_stage;
  localparam logic [4:0] OP_NOP = 5'd0, OP_MOV = 5'd1, OP_ADD = 5'd2, OP_SUB = 5'd3, OP_AND = 5'd4,
                         OP_OR = 5'd5, OP_NOT = 5'd6, OP_MULT = 5'd7, OP_DIV = 5'd8,
                         OP_CMP = 5'd9, OP_OBC = 5'd10, OP_VG = 5'd11, OP_LEFT = 5'd12,
                         OP_RIGHT = 5'd13, OP_STOP = 5'd14, OP_CONT = 5'd15, OP_LD = 5'd16,
                         OP_JMP = 5'd17, OP_BAD = 5'd31;
  typedef struct {
    int          due;
    int          kind;
    logic [15:0] val;
    logic [3:0]  addr;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  logic [41:0] fifo_data;
  logic fifo_empty;
  logic fifo_rd_en, WB_reg_write, car_cmd_valid, cmp_eq, cmp_lt, busy;
  logic [15:0] WB_data;
  logic [3:0] WB_reg_addr;
  logic [1:0] car_cmd;
  exp_t sb[$];
  logic [41:0] pkts[$];
  int cyc = 0, busy_end = -1, checks = 0, errors = 0;
  logic [15:0] m_wb = 16'h0;
  logic [3:0] m_addr = 4'h0;
  logic [1:0] m_cmd = 2'b10;
  logic m_eq = 1'b0, m_lt = 1'b0;
  ex_stage dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .WB_data(WB_data), .WB_reg_addr(WB_reg_addr),
    .WB_reg_write(WB_reg_write), .car_cmd(car_cmd), .car_cmd_valid(car_cmd_valid),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic drive();
    fifo_empty = pkts.size() == 0;
    fifo_data = fifo_empty ? {10'($urandom), $urandom} : pkts[0];
  endtask
  task automatic load(input logic [4:0] op, input logic [3:0] rd, input logic [15:0] a, input logic [15:0] b);
    pkts.push_back({op, rd, a, b, 1'($urandom)});
    drive();
  endtask
  task automatic predict(input logic [41:0] p);
    logic [4:0] op;
    logic [15:0] a, b;
    int lat;
    exp_t e;
    op = p[41:37];
    a = p[32:17];
    b = p[16:1];
    lat = (op == OP_DIV && b != 16'h0) ? 18 : 2;
    busy_end = cyc + lat - 1;
    e.due = cyc + lat;
    e.addr = p[36:33];
    e.kind = -1;
    e.val = 16'h0;
    case (op)
      OP_MOV:   begin e.kind = 0; e.val = a; end
      OP_ADD:   begin e.kind = 0; e.val = a + b; end
      OP_SUB:   begin e.kind = 0; e.val = a - b; end
      OP_AND:   begin e.kind = 0; e.val = a & b; end
      OP_OR:    begin e.kind = 0; e.val = a | b; end
      OP_NOT:   begin e.kind = 0; e.val = ~a; end
      OP_MULT:  begin e.kind = 0; e.val = 16'((32'(a) * 32'(b)) & 32'hFFFF); end
      OP_DIV:   begin e.kind = 0; e.val = b == 16'h0 ? 16'hFFFF : a / b; end
      OP_CMP:   begin e.kind = 2; e.val = {14'h0, a < b, a == b}; end
      OP_OBC:   begin e.kind = 0; e.val = {15'h0, a < 16'd100}; end
      OP_VG:    begin e.kind = 0; e.val = {15'h0, a > 16'd60}; end
      OP_LEFT:  begin e.kind = 1; e.val = 16'd0; end
      OP_RIGHT: begin e.kind = 1; e.val = 16'd1; end
      OP_STOP:  begin e.kind = 1; e.val = 16'd2; end
      OP_CONT:  begin e.kind = 1; e.val = 16'd3; end
      default:  ;
    endcase
    if (e.kind >= 0) sb.push_back(e);
    if (op == OP_OBC || op == OP_VG) begin
      e.kind = 1;
      e.val = e.val[0] ? 16'd2 : 16'd3;
      sb.push_back(e);
    end
  endtask
  task automatic tick();
    bit ew, ec, pend;
    exp_t e;
    @(negedge clk);
    ew = 0;
    ec = 0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.kind == 0) begin ew = 1; m_wb = e.val; m_addr = e.addr; end
      else if (e.kind == 1) begin ec = 1; m_cmd = e.val[1:0]; end
      else begin m_eq = e.val[0]; m_lt = e.val[1]; end
    end
    pend = reset && cyc > busy_end && pkts.size() > 0;
    check("busy", busy, cyc <= busy_end);
    check("fifo_rd_en", fifo_rd_en, pend);
    check("wb_reg_write", WB_reg_write, ew);
    check("wb_data", WB_data, m_wb);
    check("wb_reg_addr", WB_reg_addr, m_addr);
    check("car_cmd_valid", car_cmd_valid, ec);
    check("car_cmd", car_cmd, m_cmd);
    check("cmp_eq", cmp_eq, m_eq);
    check("cmp_lt", cmp_lt, m_lt);
    if (pend) predict(pkts[0]);
    @(posedge clk);
    cyc++;
    #1;
    if (pend) pkts.delete(0);
    drive();
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic check_reset();
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_wb_data", WB_data, 0);
    check("rst_wb_addr", WB_reg_addr, 0);
    check("rst_wb_we", WB_reg_write, 0);
    check("rst_car_cmd", car_cmd, 2'b10);
    check("rst_cmd_valid", car_cmd_valid, 0);
    check("rst_cmp_eq", cmp_eq, 0);
    check("rst_cmp_lt", cmp_lt, 0);
    sb.delete();
    busy_end = -1;
    m_wb = 16'h0;
    m_addr = 4'h0;
    m_cmd = 2'b10;
    m_eq = 1'b0;
    m_lt = 1'b0;
  endtask
  initial begin
    reset = 1'b0;
    load(OP_ADD, 4'd3, 16'hABCD, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    reset = 1'b1;
    run(6);
    load(OP_DIV, 4'd5, 16'd100, 16'd7);
    load(OP_DIV, 4'd2, 16'd9, 16'd0);
    run(25);
    load(OP_OBC, 4'd6, 16'd50, 16'h0);
    load(OP_OBC, 4'd6, 16'd100, 16'h0);
    load(OP_VG, 4'd7, 16'd61, 16'h0);
    load(OP_VG, 4'd7, 16'd60, 16'h0);
    run(12);
    load(OP_ADD, 4'd1, 16'hFFFF, 16'h0002);
    load(OP_SUB, 4'd2, 16'h0003, 16'h0005);
    load(OP_CMP, 4'd0, 16'd5, 16'd5);
    load(OP_RIGHT, 4'd0, 16'h0, 16'h0);
    run(10);
    load(OP_MOV, 4'd8, 16'h1357, 16'h0);
    load(OP_AND, 4'd9, 16'hF0F0, 16'h3C3C);
    load(OP_OR, 4'd10, 16'hF0F0, 16'h0F01);
    load(OP_NOT, 4'd11, 16'h00FF, 16'h0);
    load(OP_MULT, 4'd12, 16'h1234, 16'h0100);
    load(OP_CMP, 4'd0, 16'd3, 16'd9);
    load(OP_LEFT, 4'd0, 16'h0, 16'h0);
    load(OP_NOP, 4'd4, 16'h1111, 16'h2222);
    load(OP_LD, 4'd4, 16'h1111, 16'h2222);
    load(OP_JMP, 4'd4, 16'h1111, 16'h2222);
    load(OP_BAD, 4'd4, 16'h1111, 16'h2222);
    load(OP_STOP, 4'd0, 16'h0, 16'h0);
    load(OP_CMP, 4'd0, 16'd9, 16'd3);
    load(OP_CONT, 4'd0, 16'h0, 16'h0);
    run(32);
    load(OP_DIV, 4'd9, 16'd1000, 16'd3);
    load(OP_ADD, 4'd1, 16'd1, 16'd1);
    run(8);
    reset = 1'b0;
    #1;
    check_reset();
    run(3);
    reset = 1'b1;
    run(6);
    run(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
